// File: rtl/stopwatch_counter_pkg.sv
// Shared definitions for the stopwatch timekeeping core.
//   DIGIT_W    : width of one BCD digit
//   SEC_WRAP   : largest seconds value (seconds wrap 59 -> 00)
//   bcd_pair_t : two-digit BCD value (tens, ones)
package stopwatch_counter_pkg;

  localparam int DIGIT_W  = 4;
  localparam int SEC_WRAP = 59;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd_pair_t;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Signal bundle between the stopwatch counter and its neighbours.
//   ONE_CLK, TWO_CLK : divided clocks from the divider, treated as data
//   PAUSE, ADJ, SEL  : pause button, adjust switch, adjust field select
//   MIN_*/SEC_*      : BCD digits towards the seven-segment stage
//   PAUSED           : counting halted
// modport master : the side driving the controls and reading the display
// modport slave  : the stopwatch counter itself
interface stopwatch_counter_if;
  import stopwatch_counter_pkg::*;

  logic               ONE_CLK;
  logic               TWO_CLK;
  logic               PAUSE;
  logic               ADJ;
  logic               SEL;
  logic [DIGIT_W-1:0] MIN_TENS;
  logic [DIGIT_W-1:0] MIN_ONES;
  logic [DIGIT_W-1:0] SEC_TENS;
  logic [DIGIT_W-1:0] SEC_ONES;
  logic               PAUSED;

  modport master (
    output ONE_CLK, TWO_CLK, PAUSE, ADJ, SEL,
    input  MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES, PAUSED
  );

  modport slave (
    input  ONE_CLK, TWO_CLK, PAUSE, ADJ, SEL,
    output MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES, PAUSED
  );

endinterface

// File: rtl/stopwatch_counter_bcd_pair_counter.sv
// Two-digit BCD up-counter that wraps from WRAP back to 00.
//   clk   : clock
//   clr   : synchronous clear to 00 (wins over inc)
//   inc   : count one step on this edge
//   value : current count, registered
//   carry : high in the cycle an inc wraps the count (combinational, so the
//           next stage can step on the same edge)
module bcd_pair_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int WRAP = SEC_WRAP
) (
  input  logic      clk,
  input  logic      clr,
  input  logic      inc,
  output bcd_pair_t value,
  output logic      carry
);

  localparam logic [DIGIT_W-1:0] WRAP_TENS = DIGIT_W'(WRAP / 10);
  localparam logic [DIGIT_W-1:0] WRAP_ONES = DIGIT_W'(WRAP % 10);
  localparam logic [DIGIT_W-1:0] NINE      = DIGIT_W'(9);

  bcd_pair_t value_reg;
  bcd_pair_t value_next;
  logic      at_wrap;

  assign at_wrap = (value_reg.tens == WRAP_TENS) && (value_reg.ones == WRAP_ONES);

  always_comb begin
    value_next = value_reg;
    if (inc) begin
      if (at_wrap) begin
        value_next = '0;
      end else if (value_reg.ones == NINE) begin
        value_next.tens = value_reg.tens + 1'b1;
        value_next.ones = '0;
      end else begin
        value_next.ones = value_reg.ones + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_next;
    end
  end

  assign value = value_reg;
  assign carry = inc & at_wrap;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping core: MM:SS BCD count with pause and manual adjust.
// The divided clocks are sampled as data in the M_CLK domain.
//   M_CLK : master clock, the only clock
//   RST   : synchronous, active-high reset
//   bus   : slave side of stopwatch_counter_if (controls in, digits out)
// Parameters:
//   SYNC_STAGES : depth of each input synchronizer (>= 2)
//   MIN_WRAP    : largest minutes value before wrapping to 00
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WRAP    = 59
) (
  input  logic                M_CLK,
  input  logic                RST,
  stopwatch_counter_if.slave  bus
);

  localparam int N_IN    = 5;
  localparam int I_ONE   = 0;
  localparam int I_TWO   = 1;
  localparam int I_PAUSE = 2;
  localparam int I_ADJ   = 3;
  localparam int I_SEL   = 4;
  localparam int N_EDGE  = 3;  // ONE_CLK, TWO_CLK and PAUSE get edge detection

  logic [N_IN-1:0]   raw;
  logic [N_IN-1:0]   synced;
  logic [N_EDGE-1:0] prev_reg;
  logic [N_EDGE-1:0] rise;
  logic              tick1, tick2, pbtn, adj_mode, sel_sec;
  logic              paused_reg;
  logic              sec_inc, min_inc, sec_carry, min_carry_unused;
  bcd_pair_t         sec_val, min_val;

  assign raw = {bus.SEL, bus.ADJ, bus.PAUSE, bus.TWO_CLK, bus.ONE_CLK};

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] stage_reg;
      always_ff @(posedge M_CLK) begin
        if (RST) begin
          stage_reg <= '0;
        end else begin
          stage_reg <= {stage_reg[SYNC_STAGES-2:0], raw[gi]};
        end
      end
      assign synced[gi] = stage_reg[SYNC_STAGES-1];
    end
  endgenerate

  // The rise is taken from the last synchronizer stage combinationally, so
  // the counter registers update on edge SYNC_STAGES+1.
  always_ff @(posedge M_CLK) begin
    if (RST) begin
      prev_reg <= '0;
    end else begin
      prev_reg <= synced[N_EDGE-1:0];
    end
  end

  assign rise     = synced[N_EDGE-1:0] & ~prev_reg;
  assign tick1    = rise[I_ONE];
  assign tick2    = rise[I_TWO];
  assign pbtn     = rise[I_PAUSE];
  assign adj_mode = synced[I_ADJ];
  assign sel_sec  = synced[I_SEL];

  // Run-mode ticks are gated by the PAUSED value before any toggle this cycle.
  assign sec_inc = (~adj_mode & tick1 & ~paused_reg) | (adj_mode & tick2 & sel_sec);
  assign min_inc = (~adj_mode & sec_carry) | (adj_mode & tick2 & ~sel_sec);

  always_ff @(posedge M_CLK) begin
    if (RST) begin
      paused_reg <= 1'b0;
    end else if (pbtn) begin
      paused_reg <= ~paused_reg;
    end
  end

  bcd_pair_counter #(.WRAP(SEC_WRAP)) u_sec (
    .clk   (M_CLK),
    .clr   (RST),
    .inc   (sec_inc),
    .value (sec_val),
    .carry (sec_carry)
  );

  // Minutes wrap silently; their carry is intentionally not consumed.
  bcd_pair_counter #(.WRAP(MIN_WRAP)) u_min (
    .clk   (M_CLK),
    .clr   (RST),
    .inc   (min_inc),
    .value (min_val),
    .carry (min_carry_unused)
  );

  assign bus.MIN_TENS = min_val.tens;
  assign bus.MIN_ONES = min_val.ones;
  assign bus.SEC_TENS = sec_val.tens;
  assign bus.SEC_ONES = sec_val.ones;
  assign bus.PAUSED   = paused_reg;

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;
  import stopwatch_counter_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int MIN_WRAP    = 59;

  logic M_CLK = 1'b0;
  logic RST   = 1'b1;

  stopwatch_counter_if sw_if();

  stopwatch_counter #(
    .SYNC_STAGES (SYNC_STAGES),
    .MIN_WRAP    (MIN_WRAP)
  ) dut (
    .M_CLK (M_CLK),
    .RST   (RST),
    .bus   (sw_if.slave)
  );

  always #5 M_CLK = ~M_CLK;

  int n_checks = 0;
  int n_fails  = 0;
  int txn_id   = 0;

  // Reference state: plain minutes/seconds integers and a pause flag.
  int m_min    = 0;
  int m_sec    = 0;
  bit m_paused = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, got, exp, txn_id);
    end
  endtask

  function automatic logic [15:0] model_digits();
    return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
  endfunction

  function automatic logic [15:0] dut_digits();
    return {sw_if.MIN_TENS, sw_if.MIN_ONES, sw_if.SEC_TENS, sw_if.SEC_ONES};
  endfunction

  function automatic void model_apply(input bit t1, input bit t2, input bit pb,
                                      input bit adj, input bit sel);
    if (!adj) begin
      if (t1 && !m_paused) begin
        m_sec++;
        if (m_sec == 60) begin
          m_sec = 0;
          m_min = (m_min == MIN_WRAP) ? 0 : m_min + 1;
        end
      end
    end else if (t2) begin
      if (sel) m_sec = (m_sec + 1) % 60;
      else     m_min = (m_min == MIN_WRAP) ? 0 : m_min + 1;
    end
    if (pb) m_paused = !m_paused;
  endfunction

  // One transaction: set levels and raise the chosen edges together, check
  // nothing moves before edge SYNC_STAGES+1, check the update on that edge,
  // hold the inputs high for 'hold' cycles, drop them, and check it settled.
  task automatic txn(input bit t1, input bit t2, input bit pb,
                     input bit adj, input bit sel, input int hold);
    logic [15:0] old_d;
    logic        old_p;
    old_d = model_digits();
    old_p = m_paused;
    @(negedge M_CLK);
    sw_if.ADJ     = adj;
    sw_if.SEL     = sel;
    sw_if.ONE_CLK = t1;
    sw_if.TWO_CLK = t2;
    sw_if.PAUSE   = pb;
    repeat (SYNC_STAGES) @(posedge M_CLK);
    #1;
    check("early_digits", 32'(dut_digits()), 32'(old_d));
    check("early_paused", 32'(sw_if.PAUSED), 32'(old_p));
    model_apply(t1, t2, pb, adj, sel);
    @(posedge M_CLK);
    #1;
    check("digits", 32'(dut_digits()), 32'(model_digits()));
    check("paused", 32'(sw_if.PAUSED), 32'(m_paused));
    repeat (hold) @(posedge M_CLK);
    @(negedge M_CLK);
    sw_if.ONE_CLK = 1'b0;
    sw_if.TWO_CLK = 1'b0;
    sw_if.PAUSE   = 1'b0;
    repeat (SYNC_STAGES + 2) @(posedge M_CLK);
    #1;
    check("settled_digits", 32'(dut_digits()), 32'(model_digits()));
    check("settled_paused", 32'(sw_if.PAUSED), 32'(m_paused));
    txn_id++;
    $display("txn %0d: t1=%0b t2=%0b pb=%0b adj=%0b sel=%0b hold=%0d -> %02h:%02h paused=%0b",
             txn_id, t1, t2, pb, adj, sel, hold, dut_digits()[15:8], dut_digits()[7:0],
             sw_if.PAUSED);
  endtask

  // One-cycle RST, optionally with a ONE_CLK pulse confined to the reset cycle.
  task automatic do_reset(input bit with_tick);
    @(negedge M_CLK);
    RST           = 1'b1;
    sw_if.ONE_CLK = with_tick;
    @(posedge M_CLK);
    #1;
    m_min    = 0;
    m_sec    = 0;
    m_paused = 1'b0;
    check("reset_digits", 32'(dut_digits()), 32'h0);
    check("reset_paused", 32'(sw_if.PAUSED), 32'h0);
    @(negedge M_CLK);
    RST           = 1'b0;
    sw_if.ONE_CLK = 1'b0;
    repeat (SYNC_STAGES + 3) @(posedge M_CLK);
    #1;
    check("post_reset_digits", 32'(dut_digits()), 32'h0);
    check("post_reset_paused", 32'(sw_if.PAUSED), 32'h0);
    txn_id++;
    $display("txn %0d: reset tick=%0b -> %02h:%02h paused=%0b",
             txn_id, with_tick, dut_digits()[15:8], dut_digits()[7:0], sw_if.PAUSED);
  endtask

  task automatic adj_ticks(input bit sel, input int n);
    for (int i = 0; i < n; i++) txn(1'b0, 1'b1, 1'b0, 1'b1, sel, 0);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    sw_if.ONE_CLK = 1'b0;
    sw_if.TWO_CLK = 1'b0;
    sw_if.PAUSE   = 1'b0;
    sw_if.ADJ     = 1'b0;
    sw_if.SEL     = 1'b0;
    repeat (4) @(posedge M_CLK);
    do_reset(1'b0);

    // Ten run ticks.
    run_ticks(10);
    check("ten_ticks", 32'(dut_digits()), 32'h0010);

    // 00:59 + 1 -> 01:00; the tick arrives together with the return to run mode.
    do_reset(1'b0);
    adj_ticks(1'b1, 59);
    check("preload_0059", 32'(dut_digits()), 32'h0059);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("carry_minute", 32'(dut_digits()), 32'h0100);

    // 59:59 + 1 -> 00:00.
    do_reset(1'b0);
    adj_ticks(1'b0, 59);
    adj_ticks(1'b1, 59);
    check("preload_5959", 32'(dut_digits()), 32'h5959);
    run_ticks(1);
    check("full_wrap", 32'(dut_digits()), 32'h0000);

    // Pause behaviour.
    run_ticks(3);
    txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    run_ticks(5);
    check("paused_hold", 32'(dut_digits()), 32'h0003);
    check("paused_flag", 32'(sw_if.PAUSED), 32'h1);
    txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    run_ticks(1);
    check("resumed", 32'(dut_digits()), 32'h0004);
    txn(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    check("pause_with_tick", 32'(dut_digits()), 32'h0005);
    check("pause_with_tick_flag", 32'(sw_if.PAUSED), 32'h1);
    txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // Adjust seconds from 00:58, then minutes from 58:xx.
    do_reset(1'b0);
    adj_ticks(1'b1, 58);
    adj_ticks(1'b1, 3);
    check("adj_sec_wrap", 32'(dut_digits()), 32'h0001);
    txn(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    check("adj_ignores_one", 32'(dut_digits()), 32'h0001);
    adj_ticks(1'b0, 58);
    check("preload_5801", 32'(dut_digits()), 32'h5801);
    adj_ticks(1'b0, 2);
    check("adj_min_wrap", 32'(dut_digits()), 32'h0001);
    txn(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20);

    // Reset mid-count at 12:34, with a ONE_CLK pulse inside the reset cycle.
    do_reset(1'b0);
    adj_ticks(1'b0, 12);
    adj_ticks(1'b1, 34);
    txn(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("preload_1234", 32'(dut_digits()), 32'h1234);
    do_reset(1'b1);

    // Long-held inputs count once per rising edge.
    txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20);
    txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 15);
    txn(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 15);
    check("held_result", 32'(dut_digits()), 32'h0101);
    check("held_paused", 32'(sw_if.PAUSED), 32'h1);
    txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);

    // Randomized mix of ticks, presses, mode and field changes.
    for (int i = 0; i < 200; i++) begin
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
